uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: the receive side of the existing uart transmitter. Samples Uart_RX_Pin
//  (8N1, LSB first) and buffers received bytes in a small FIFO. Presents them on a
//  valid/ready handshake to the top-level logic (e.g. to forward to spi_data_to_send).
//  Runs on the 27 MHz system clock. Flags framing errors and FIFO overruns.
// PARAMETERS
//  CLOCK_FREQUENCY  27000000  system clock in Hz
//  BAUD_RATE        115200    line rate; CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (234, truncated)
//  FIFO_DEPTH       8         receive FIFO entries; power of two, >= 2
// PORTS
//  clk            in   1   system clock, single clock domain
//  rst            in   1   synchronous reset, active-high
//  uart_rx_pin    in   1   asynchronous serial input, idle high
//  rx_data        out  8   head-of-FIFO byte, valid while rx_valid=1
//  rx_valid       out  1   FIFO not empty
//  rx_ready       in   1   consumer pops head when rx_valid && rx_ready at posedge
//  rx_fifo_count  out  $clog2(FIFO_DEPTH+1)  bytes currently held
//  framing_error  out  1   1-cycle pulse: stop bit sampled low
//  overrun        out  1   1-cycle pulse: good byte dropped because FIFO full
// BEHAVIOUR
//  Reset: FSM=IDLE, sync flops=1, counters=0, FIFO empty. rx_valid=0, rx_fifo_count=0,
//   framing_error=0, overrun=0, rx_data=0. Reset mid-frame aborts; partial byte discarded.
//  Input: 2-flop synchroniser; all decisions use the second flop (rx_s).
//  FSM:
//   IDLE:  rx_s==0 -> START, bit_cnt clk counter=0.
//   START: at counter==CLKS_PER_BIT/2-1 sample rx_s. 0 -> DATA (counter=0, bit_idx=0).
//          1 -> IDLE (glitch; no flag raised).
//   DATA:  at counter==CLKS_PER_BIT-1 sample rx_s and shift into shreg[7] (right shift, LSB first).
//          Counter resets. After bit_idx 7 -> STOP.
//   STOP:  at counter==CLKS_PER_BIT-1 sample rx_s. 1 -> push shreg, go to IDLE.
//          0 -> framing_error pulse, byte discarded, go to WAIT_IDLE.
//   WAIT_IDLE: stay until rx_s==1, then IDLE (prevents break/low line re-triggering).
//  Latency: pushed byte appears on rx_valid/rx_data on the cycle after the stop-bit sample.
//  FIFO: show-ahead; rx_data = mem[rd_ptr]. Pointers wrap modulo FIFO_DEPTH.
//   Push when full and no pop: byte dropped, overrun pulses, FIFO contents unchanged.
//   Push and pop in the same cycle when full: both happen, no overrun, count unchanged.
//   Push and pop in the same cycle when empty: push only (rx_valid was 0).
//   Pop when empty: ignored.
//  framing_error and overrun are never asserted in the same cycle. Both are registered.
//  Back-to-back frames with exactly one stop bit are received without loss.
//  Sampling tolerates +/-2% baud mismatch.
// STRUCTURE
//  Shared package/header: UART state encodings (IDLE/START/DATA/STOP/WAIT_IDLE) and the
//   CLKS_PER_BIT derivation, shared with the uart transmitter.
//  One sub-module: uart_rx_fifo (sync FIFO, width 8, depth FIFO_DEPTH, show-ahead,
//   push/pop/full/empty/count). The FSM and synchroniser stay in uart_rx.
// TESTING  (defaults: CLKS_PER_BIT=234; bench drives bits 234 clk wide)
//  1. rx_ready=1, send 0x55 stop=1 -> rx_valid high 1 cycle, rx_data=0x55, no flags.
//  2. Low glitch of 50 clk on idle line -> no rx_valid, no framing_error, FSM back to IDLE.
//  3. Send 0xA3 with stop=0, line held low 1000 clk, then high -> framing_error one pulse.
//     No rx_valid. Then a 0x3C frame is received correctly.
//  4. rx_ready=0, send 0x00..0x08 -> count=8, overrun pulses once on the 9th byte.
//     Then with rx_ready=1, pops return 0x00..0x07 in order and count returns to 0.
//  5. Assert rst during DATA bit 4 of 0x99 -> outputs at reset values. The following 0x42
//     frame is received as 0x42.
//  6. Back-to-back 0xFF,0x00,0x81 with one stop bit each, rx_ready=1 -> three bytes in order.
//     With FIFO full and rx_ready=1 during a push, no overrun.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-period derivation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

    // Whole system clocks per serial bit; the fractional part is truncated.
    function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO holding received bytes until the consumer pops them.
module uart_rx_fifo
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        rd_data = empty ? '0 : mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, deframes bytes and queues them in a FIFO.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            uart_rx_pin,
    output logic [7:0]                      rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_fifo_count,
    output logic                            framing_error,
    output logic                            overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic             sync_q, sync_d;
    logic             rx_s_q, rx_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             framing_error_q, framing_error_d;
    logic             overrun_q, overrun_d;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;

    // Every sampling decision is made on rx_s_q, the second synchroniser stage.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shreg_d         = shreg_q;
        push            = 1'b0;
        framing_error_d = 1'b0;
        sync_d          = uart_rx_pin;
        rx_s_d          = sync_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) must return high before a new start can be seen.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        overrun_d = push && fifo_full && !(rx_ready && !fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            sync_q          <= 1'b1;
            rx_s_q          <= 1'b1;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shreg_q         <= '0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            rx_s_q          <= rx_s_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shreg_q         <= shreg_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (shreg_q),
        .pop     (rx_ready),
        .rd_data (rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (rx_fifo_count)
    );

    assign rx_valid      = !fifo_empty;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: queue-based reference model plus directed literal checks.
module tb_uart_rx;

    localparam int CPB   = 234;
    localparam int DEPTH = 8;
    // Edges from the first clock that sees the start bit to the stop-bit decision:
    // two synchroniser stages, half a bit to the start-bit centre, nine more whole bits.
    localparam int PUSH_LAT = 2 + CPB/2 + 9*CPB;

    typedef struct {
        int         at_cyc;
        logic [7:0] data;
        bit         good;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       uart_rx_pin;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_fifo_count;
    logic       framing_error;
    logic       overrun;

    ev_t        ev_q[$];
    logic [7:0] model_q[$];
    logic [7:0] dut_pops[$];
    logic [7:0] exp_pops[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    int         fe_pulses = 0;
    int         ov_pulses = 0;
    bit         exp_fe = 1'b0;
    bit         exp_ov = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rnd_done = 1'b0;

    uart_rx #(
        .CLOCK_FREQUENCY (27000000),
        .BAUD_RATE       (115200),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_pin   (uart_rx_pin),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_fifo_count (rx_fifo_count),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: FIFO as a queue, frames as scheduled decision events.
    task automatic modelStep();
        bit popped;
        bit was_full;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (rst) begin
            model_q.delete();
            ev_q.delete();
            return;
        end
        was_full = (model_q.size() == DEPTH);
        popped   = (model_q.size() != 0) && (rx_ready == 1'b1);
        if (popped) void'(model_q.pop_front());
        if (ev_q.size() != 0 && ev_q[0].at_cyc == cyc) begin
            if (!ev_q[0].good) exp_fe = 1'b1;
            else if (was_full && !popped) exp_ov = 1'b1;
            else model_q.push_back(ev_q[0].data);
            void'(ev_q.pop_front());
        end
    endtask

    task automatic compareCycle();
        checkOutput("rx_valid", 32'(rx_valid), 32'(model_q.size() != 0));
        checkOutput("rx_fifo_count", 32'(rx_fifo_count), 32'(model_q.size()));
        if (model_q.size() != 0) checkOutput("rx_data", 32'(rx_data), 32'(model_q[0]));
        else if (rst) checkOutput("rx_data_in_reset", 32'(rx_data), 32'(0));
        checkOutput("framing_error", 32'(framing_error), 32'(exp_fe));
        checkOutput("overrun", 32'(overrun), 32'(exp_ov));
    endtask

    // Outputs are sampled 1 time unit after each rising edge; inputs change on falling edges.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst && prev_valid && rx_ready === 1'b1) dut_pops.push_back(prev_data);
            if (rx_valid === 1'b1) valid_cycles++;
            if (framing_error === 1'b1) fe_pulses++;
            if (overrun === 1'b1) ov_pulses++;
            prev_valid = (rx_valid === 1'b1);
            prev_data  = rx_data;
            modelStep();
            compareCycle();
        end
    end

    initial begin
        repeat (99000) @(posedge clk);
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: reached cycle %0d, required finish before 99000", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic idle(input int n);
        uart_rx_pin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current falling edge; schedules its model event.
    task automatic applyStimulus(input logic [7:0] data, input bit stop, input int width);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_pin = bits[i];
            if (i == 0) ev_q.push_back('{cyc + 1 + PUSH_LAT, data, stop});
            repeat (width) @(negedge clk);
        end
    endtask

    task automatic clearObs();
        valid_cycles = 0;
        fe_pulses    = 0;
        ov_pulses    = 0;
        dut_pops.delete();
    endtask

    task automatic checkPops(input string name);
        checkOutput({name, "_pop_count"}, 32'(dut_pops.size()), 32'(exp_pops.size()));
        for (int i = 0; i < exp_pops.size() && i < dut_pops.size(); i++)
            checkOutput({name, "_pop_data"}, 32'(dut_pops[i]), 32'(exp_pops[i]));
    endtask

    initial begin
        logic [7:0] partial;
        rst = 1'b1;
        uart_rx_pin = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'(0));
        checkOutput("reset_count", 32'(rx_fifo_count), 32'(0));
        checkOutput("reset_rx_data", 32'(rx_data), 32'(0));
        checkOutput("reset_flags", 32'({framing_error, overrun}), 32'(0));
        rst = 1'b0;
        idle(20);

        $display("[TB] single byte 0x55");
        clearObs();
        applyStimulus(8'h55, 1'b1, CPB);
        idle(50);
        exp_pops = '{8'h55};
        checkPops("t1");
        checkOutput("t1_valid_cycles", 32'(valid_cycles), 32'(1));
        checkOutput("t1_flags", 32'(fe_pulses + ov_pulses), 32'(0));

        $display("[TB] 50-clock glitch");
        clearObs();
        uart_rx_pin = 1'b0;
        repeat (50) @(negedge clk);
        idle(400);
        checkOutput("t2_valid_cycles", 32'(valid_cycles), 32'(0));
        checkOutput("t2_framing", 32'(fe_pulses), 32'(0));

        $display("[TB] bad stop bit then recovery");
        clearObs();
        applyStimulus(8'hA3, 1'b0, CPB);
        repeat (1000) @(negedge clk);
        idle(100);
        checkOutput("t3_framing_pulses", 32'(fe_pulses), 32'(1));
        checkOutput("t3_valid_cycles", 32'(valid_cycles), 32'(0));
        clearObs();
        applyStimulus(8'h3C, 1'b1, CPB);
        idle(50);
        exp_pops = '{8'h3C};
        checkPops("t3");
        checkOutput("t3_framing_after", 32'(fe_pulses), 32'(0));

        $display("[TB] fill FIFO and overrun");
        rx_ready = 1'b0;
        clearObs();
        for (int i = 0; i < 9; i++) applyStimulus(8'(i), 1'b1, CPB);
        checkOutput("t4_count_full", 32'(rx_fifo_count), 32'(8));
        checkOutput("t4_overrun_pulses", 32'(ov_pulses), 32'(1));
        checkOutput("t4_head", 32'(rx_data), 32'(0));
        fork
            applyStimulus(8'h09, 1'b1, CPB);
            begin
                repeat (PUSH_LAT) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                checkOutput("t6_full_push_pop_count", 32'(rx_fifo_count), 32'(8));
                checkOutput("t6_full_push_pop_overrun", 32'(overrun), 32'(0));
            end
        join
        idle(50);
        exp_pops.delete();
        for (int i = 0; i < 8; i++) exp_pops.push_back(8'(i));
        exp_pops.push_back(8'h09);
        checkPops("t4");
        checkOutput("t4_overrun_total", 32'(ov_pulses), 32'(1));
        checkOutput("t4_count_drained", 32'(rx_fifo_count), 32'(0));

        $display("[TB] reset during data bit 4");
        rx_ready = 1'b0;
        clearObs();
        applyStimulus(8'h11, 1'b1, CPB);
        checkOutput("t5_count_before", 32'(rx_fifo_count), 32'(1));
        partial = 8'h99;
        uart_rx_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            uart_rx_pin = partial[b];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_pin = partial[4];
        repeat (100) @(negedge clk);
        rst = 1'b1;
        uart_rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t5_reset_count", 32'(rx_fifo_count), 32'(0));
        checkOutput("t5_reset_valid", 32'(rx_valid), 32'(0));
        checkOutput("t5_reset_data", 32'(rx_data), 32'(0));
        checkOutput("t5_reset_flags", 32'({framing_error, overrun}), 32'(0));
        rst = 1'b0;
        idle(300);
        rx_ready = 1'b1;
        clearObs();
        applyStimulus(8'h42, 1'b1, CPB);
        idle(50);
        exp_pops = '{8'h42};
        checkPops("t5");
        checkOutput("t5_framing", 32'(fe_pulses), 32'(0));

        $display("[TB] back-to-back frames");
        clearObs();
        applyStimulus(8'hFF, 1'b1, CPB);
        applyStimulus(8'h00, 1'b1, CPB);
        applyStimulus(8'h81, 1'b1, CPB);
        idle(50);
        exp_pops = '{8'hFF, 8'h00, 8'h81};
        checkPops("t6");
        checkOutput("t6_flags", 32'(fe_pulses + ov_pulses), 32'(0));

        $display("[TB] randomized frames, baud skew and consumer stalls");
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 12; f++) begin
                    int w;
                    bit good;
                    w = int'($urandom_range(230, 238));
                    good = ($urandom_range(0, 5) != 0);
                    applyStimulus(8'($urandom_range(0, 255)), good, w);
                    idle(good ? int'($urandom_range(0, 150)) : int'($urandom_range(20, 150)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    rx_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rx_ready = 1'b1;
        idle(100);
        checkOutput("rand_drain_count", 32'(rx_fifo_count), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
